// File: rtl/iter_divider_if.sv
// Handshake/data bundle between the EX stage and the iterative divider.
interface iter_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 div_en;
  logic                 flush;
  logic                 signed_div;
  logic [WIDTH-1:0]     op1;
  logic [WIDTH-1:0]     op2;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result_div;

  modport master (
    output div_en, flush, signed_div, op1, op2,
    input  busy, done, result_div
  );

  modport slave (
    input  div_en, flush, signed_div, op1, op2,
    output busy, done, result_div
  );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider, RISC-V DIV/DIVU/REM/REMU semantics.
// result_div = {remainder, quotient}. Signed support is built only when
// DIVIDER_SIGNED_EN is defined; otherwise signed_div is ignored.
module iter_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  iter_divider_if.slave dif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     rem_q, quo_q, dvs_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   res_q, res_nxt;
  logic                 res_load;

  logic                 start, div_zero, ovf;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     rem_step, quo_step, rem_fin, quo_fin;

`ifdef DIVIDER_SIGNED_EN
  logic                 a_neg, b_neg;
  logic                 neg_q_q, neg_r_q;
`endif

  // Operand conditioning: magnitudes and shortcut detection at start
  always_comb begin
    start    = dif.div_en && !dif.flush && (state == IDLE || state == FIN);
    div_zero = (dif.op2 == '0);
`ifdef DIVIDER_SIGNED_EN
    a_neg = dif.signed_div && dif.op1[WIDTH-1];
    b_neg = dif.signed_div && dif.op2[WIDTH-1];
    a_mag = a_neg ? (~dif.op1 + 1'b1) : dif.op1;
    b_mag = b_neg ? (~dif.op2 + 1'b1) : dif.op2;
    ovf   = dif.signed_div && (dif.op1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
            (dif.op2 == '1);
`else
    a_mag = dif.op1;
    b_mag = dif.op2;
    ovf   = 1'b0;
`endif
  end

  // One restoring step, plus sign correction of the final step's outcome
  always_comb begin
    trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    rem_step = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
`ifdef DIVIDER_SIGNED_EN
    quo_fin  = neg_q_q ? (~quo_step + 1'b1) : quo_step;
    rem_fin  = neg_r_q ? (~rem_step + 1'b1) : rem_step;
`else
    quo_fin  = quo_step;
    rem_fin  = rem_step;
`endif
  end

  // Next-state and result-load decision; flush overrides everything
  always_comb begin
    state_nxt = state;
    res_load  = 1'b0;
    res_nxt   = res_q;
    case (state)
      IDLE, FIN: begin
        if (start) begin
          if (div_zero) begin
            state_nxt = FIN;
            res_load  = 1'b1;
            res_nxt   = {dif.op1, {WIDTH{1'b1}}};
          end else if (ovf) begin
            state_nxt = FIN;
            res_load  = 1'b1;
            res_nxt   = {{WIDTH{1'b0}}, dif.op1};
          end else begin
            state_nxt = CALC;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (cnt_q == LAST) begin
          state_nxt = FIN;
          res_load  = 1'b1;
          res_nxt   = {rem_fin, quo_fin};
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (dif.flush) begin
      state_nxt = IDLE;
      res_load  = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Result register: written only on entry to FIN
  always_ff @(posedge clk) begin
    if (rst)           res_q <= '0;
    else if (res_load) res_q <= res_nxt;
  end

  // Iteration datapath: latch operands on start, shift/subtract in CALC
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
`ifdef DIVIDER_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else if (start) begin
      rem_q <= '0;
      quo_q <= a_mag;
      dvs_q <= b_mag;
      cnt_q <= '0;
`ifdef DIVIDER_SIGNED_EN
      neg_q_q <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
`endif
    end else if (state == CALC) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign dif.busy       = (state == CALC);
  assign dif.done       = (state == FIN);
  assign dif.result_div = res_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider (WIDTH=32).
module tb_iter_divider;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  iter_divider_if #(.WIDTH(W)) dif ();

  iter_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start, take edge T, then scramble inputs to prove they were latched.
  task automatic start(input logic s, input logic [31:0] a, input logic [31:0] b);
    dif.signed_div = s;
    dif.op1        = a;
    dif.op2        = b;
    dif.div_en     = 1'b1;
    tick();
    dif.div_en     = 1'b0;
    dif.op1        = ~a;
    dif.op2        = b + 32'd1;
    dif.signed_div = ~s;
  endtask

  // Called in cycle T+1; lat counts cycles after edge T until done.
  task automatic wait_result(input string tag, input int exp_lat, input logic [63:0] exp_res);
    int          lat = 1;
    logic        busy_bad = 1'b0;
    logic        res_moved = 1'b0;
    logic [63:0] prev = dif.result_div;
    while (dif.done !== 1'b1 && lat < 200) begin
      if (dif.busy !== 1'b1) busy_bad = 1'b1;
      if (dif.result_div !== prev) res_moved = 1'b1;
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, dif.result_div, exp_res);
    chk({tag, " busy at done"}, 64'(dif.busy), 64'(0));
    if (exp_lat > 1) begin
      chk({tag, " busy during calc"}, 64'(busy_bad), 64'(0));
      chk({tag, " result held"}, 64'(res_moved), 64'(0));
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    start(s, a, b);
    wait_result(tag, exp_lat, exp_res);
    tick();
    chk({tag, " done one cycle"}, 64'(dif.done), 64'(0));
  endtask

  initial begin
    logic [63:0] saved;
    rst            = 1'b1;
    dif.div_en     = 1'b0;
    dif.flush      = 1'b0;
    dif.signed_div = 1'b0;
    dif.op1        = '0;
    dif.op2        = '0;
    tick();
    tick();
    chk("reset busy", 64'(dif.busy), 64'(0));
    chk("reset done", 64'(dif.done), 64'(0));
    chk("reset result", dif.result_div, 64'h0);
    rst = 1'b0;
    tick();

    run_op("u 100/7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    run_op("u 0/5", 1'b0, 32'd0, 32'd5, 33, {32'd0, 32'd0});
    run_op("u max/1", 1'b0, 32'hFFFFFFFF, 32'd1, 33, {32'd0, 32'hFFFFFFFF});
    run_op("u 5/9", 1'b0, 32'd5, 32'd9, 33, {32'd5, 32'd0});
    run_op("div0", 1'b0, 32'h1234, 32'd0, 1, {32'h1234, 32'hFFFFFFFF});
    run_op("s div0 neg", 1'b1, 32'hFFFFFFF9, 32'd0, 1, {32'hFFFFFFF9, 32'hFFFFFFFF});
    run_op("u 8000/FFFF", 1'b0, 32'h80000000, 32'hFFFFFFFF, 33, {32'h80000000, 32'h0});
`ifdef DIVIDER_SIGNED_EN
    run_op("s -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("s 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, {32'd1, 32'hFFFFFFFD});
    run_op("s -8/-3", 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 33, {32'hFFFFFFFE, 32'd2});
    run_op("s ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1, {32'h0, 32'h80000000});
`else
    run_op("s -7/2 as u", 1'b1, 32'hFFFFFFF9, 32'd2, 33, {32'd1, 32'h7FFFFFFC});
    run_op("s 7/-2 as u", 1'b1, 32'd7, 32'hFFFFFFFE, 33, {32'd7, 32'd0});
    run_op("s -8/-3 as u", 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 33, {32'hFFFFFFF8, 32'd0});
    run_op("s ovf as u", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, {32'h80000000, 32'h0});
`endif

    // Flush at T+10 together with a competing div_en
    saved = dif.result_div;
    start(1'b0, 32'd1000, 32'd3);
    repeat (9) tick();
    dif.flush  = 1'b1;
    dif.div_en = 1'b1;
    dif.op1    = 32'd77;
    dif.op2    = 32'd7;
    tick();
    dif.flush  = 1'b0;
    dif.div_en = 1'b0;
    chk("flush busy", 64'(dif.busy), 64'(0));
    chk("flush done", 64'(dif.done), 64'(0));
    chk("flush result kept", dif.result_div, saved);
    run_op("after flush", 1'b0, 32'd1000, 32'd3, 33, {32'd1, 32'd333});

    // Reset mid-operation
    start(1'b0, 32'd100, 32'd7);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", 64'(dif.busy), 64'(0));
    chk("midrst done", 64'(dif.done), 64'(0));
    chk("midrst result", dif.result_div, 64'h0);
    tick();

    // div_en held high: ignored while busy, restarts back-to-back in FIN
    dif.signed_div = 1'b0;
    dif.op1        = 32'd100;
    dif.op2        = 32'd7;
    dif.div_en     = 1'b1;
    tick();
    dif.op1 = 32'd1000;
    dif.op2 = 32'd10;
    wait_result("b2b first", 33, {32'd2, 32'd14});
    tick();
    dif.div_en = 1'b0;
    dif.op1    = 32'd5;
    dif.op2    = 32'd5;
    chk("b2b restart busy", 64'(dif.busy), 64'(1));
    wait_result("b2b second", 33, {32'd0, 32'd100});
    tick();
    chk("b2b idle", 64'(dif.done), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
